// File: rtl/cpu_timing.sv
// 8008 T-state / machine-cycle sequencer: walks T1..T5, WAIT and STOPPED and plans
// the remaining machine cycles from the decoded instruction class in T4 of cycle 1.
module cpu_timing (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       READY_I,
  input  logic       INT_I,
  input  logic [7:0] IR_I,
  input  logic       D_LOAD_I,
  input  logic       D_ALU_I,
  input  logic       D_JUMP_I,
  input  logic       D_CALL_I,
  input  logic       D_RET_I,
  input  logic       D_RST_I,
  input  logic       D_INP_I,
  input  logic       D_OUT_I,
  input  logic       D_SRC_M_I,
  input  logic       D_SRC_I_I,
  input  logic       D_DST_M_I,
  output logic [2:0] STATE_O,
  output logic [1:0] CYCLE_O,
  output logic [1:0] CYC_NUM_O,
  output logic       SYNC_O,
  output logic       IR_LD_O,
  output logic       INT_ACK_O,
  output logic       INSTR_END_O
);

  typedef enum logic [2:0] {
    T1 = 3'b010, T1I = 3'b011, T2 = 3'b001, TW = 3'b000,
    T3 = 3'b100, STOP = 3'b110, T4 = 3'b111, T5 = 3'b101
  } tstate_e;

  typedef enum logic [1:0] {PCI = 2'b00, PCR = 2'b01, PCC = 2'b10, PCW = 2'b11} cyc_e;

  typedef struct packed {
    logic [1:0] n;   // total machine cycles in the instruction
    cyc_e       c2;
    cyc_e       c3;
  } plan_t;

  localparam plan_t PLAN_CLR = '{n: 2'd1, c2: PCI, c3: PCI};

  tstate_e    st, st_nx;
  cyc_e       cyc, cyc_nx;
  logic [1:0] num, num_nx;
  plan_t      plan, plan_nx, dec;
  logic       halt;

  // Instruction class -> cycle plan, highest-priority class wins.
  always_comb begin
    dec  = PLAN_CLR;
    halt = (IR_I == 8'h00) || (IR_I == 8'h01) || (IR_I == 8'hFF);
    if (halt)                        dec = PLAN_CLR;
    else if (D_JUMP_I || D_CALL_I)   dec = '{n: 2'd3, c2: PCR, c3: PCR};
    else if (D_INP_I || D_OUT_I)     dec = '{n: 2'd2, c2: PCC, c3: PCI};
    else if (D_RET_I || D_RST_I)     dec = PLAN_CLR;
    else if (D_LOAD_I || D_ALU_I) begin
      if (D_DST_M_I && D_SRC_I_I)    dec = '{n: 2'd3, c2: PCR, c3: PCW};
      else if (D_DST_M_I)            dec = '{n: 2'd2, c2: PCW, c3: PCI};
      else if (D_SRC_M_I || D_SRC_I_I) dec = '{n: 2'd2, c2: PCR, c3: PCI};
    end
  end

  always_comb begin
    st_nx   = st;
    cyc_nx  = cyc;
    num_nx  = num;
    plan_nx = plan;
    case (st)
      T1, T1I: st_nx = T2;
      T2:      st_nx = READY_I ? T3 : TW;
      TW:      if (READY_I) st_nx = T3;
      T3: begin
        if (num == 2'd1 || num == plan.n) st_nx = T4;
        else begin
          // only an intermediate cycle 2 gets here, so cycle 3 follows
          st_nx  = T1;
          num_nx = num + 2'd1;
          cyc_nx = plan.c3;
        end
      end
      T4: begin
        if (num == 2'd1) begin
          plan_nx = dec;
          if (halt)                st_nx = STOP;
          else if (dec.n == 2'd1)  st_nx = T5;
          else begin
            st_nx  = T1;
            num_nx = 2'd2;
            cyc_nx = dec.c2;
          end
        end else st_nx = T5;
      end
      T5: begin
        st_nx  = INT_I ? T1I : T1;
        num_nx = 2'd1;
        cyc_nx = PCI;
      end
      STOP: begin
        if (INT_I) begin
          st_nx  = T1I;
          num_nx = 2'd1;
          cyc_nx = PCI;
        end
      end
      default: st_nx = T1;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      st   <= T1;
      cyc  <= PCI;
      num  <= 2'd1;
      plan <= PLAN_CLR;
    end else begin
      st   <= st_nx;
      cyc  <= cyc_nx;
      num  <= num_nx;
      plan <= plan_nx;
    end
  end

  assign STATE_O     = st;
  assign CYCLE_O     = cyc;
  assign CYC_NUM_O   = num;
  assign SYNC_O      = (st == T1) || (st == T1I);
  assign IR_LD_O     = (st == T3) && (num == 2'd1);
  assign INT_ACK_O   = (st == T1I);
  assign INSTR_END_O = (st == T5);

endmodule

// File: tb/tb_cpu_timing.sv
// Directed bench for cpu_timing: hand-written state/cycle sequences per instruction class,
// wait states, halt/interrupt handling and reset during a wait.
module tb_cpu_timing;

  logic       clk = 1'b0;
  logic       rst_n, ready, intr;
  logic [7:0] ir;
  logic       d_load, d_alu, d_jump, d_call, d_ret, d_rst, d_inp, d_out;
  logic       d_src_m, d_src_i, d_dst_m;
  logic [2:0] state;
  logic [1:0] cycle, cyc_num;
  logic       sync, ir_ld, int_ack, instr_end;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] ST1 = 3'b010, ST1I = 3'b011, ST2 = 3'b001, SW = 3'b000,
                         ST3 = 3'b100, SSTP = 3'b110, ST4 = 3'b111, ST5 = 3'b101;
  localparam logic [1:0] PCI = 2'b00, PCR = 2'b01, PCC = 2'b10, PCW = 2'b11;

  always #5 clk = ~clk;

  cpu_timing dut (
    .CLK_I(clk), .RST_N_I(rst_n), .READY_I(ready), .INT_I(intr), .IR_I(ir),
    .D_LOAD_I(d_load), .D_ALU_I(d_alu), .D_JUMP_I(d_jump), .D_CALL_I(d_call),
    .D_RET_I(d_ret), .D_RST_I(d_rst), .D_INP_I(d_inp), .D_OUT_I(d_out),
    .D_SRC_M_I(d_src_m), .D_SRC_I_I(d_src_i), .D_DST_M_I(d_dst_m),
    .STATE_O(state), .CYCLE_O(cycle), .CYC_NUM_O(cyc_num),
    .SYNC_O(sync), .IR_LD_O(ir_ld), .INT_ACK_O(int_ack), .INSTR_END_O(instr_end)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [1:0] cy,
                      input logic [1:0] nm);
    tick();
    chk({tag, ".state"}, state, st);
    chk({tag, ".cycle"}, cycle, cy);
    chk({tag, ".num"}, cyc_num, nm);
  endtask

  task automatic clr_dec();
    {d_load, d_alu, d_jump, d_call, d_ret, d_rst, d_inp, d_out} = '0;
    {d_src_m, d_src_i, d_dst_m} = '0;
    ir = 8'hC1;
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; intr = 1'b0;
    clr_dec();

    // reset state
    tick(); tick();
    chk("rst.state", state, ST1);
    chk("rst.cycle", cycle, PCI);
    chk("rst.num", cyc_num, 1);
    chk("rst.sync", sync, 1);
    chk("rst.strobes", {ir_ld, int_ack, instr_end}, 0);
    rst_n = 1'b1;

    // reg-reg load: T1 T2 T3 T4 T5 T1
    d_load = 1'b1;
    step("ld.t2", ST2, PCI, 1);
    chk("ld.t2.irld", ir_ld, 0);
    step("ld.t3", ST3, PCI, 1);
    chk("ld.t3.irld", ir_ld, 1);
    step("ld.t4", ST4, PCI, 1);
    chk("ld.t4.end", instr_end, 0);
    step("ld.t5", ST5, PCI, 1);
    chk("ld.t5.end", instr_end, 1);
    step("ld.next", ST1, PCI, 1);
    chk("ld.next.sync", sync, 1);

    // LMI: PCI (with its decode T4), PCR, PCW
    d_src_i = 1'b1; d_dst_m = 1'b1;
    step("lmi.c1t2", ST2, PCI, 1);
    step("lmi.c1t3", ST3, PCI, 1);
    step("lmi.c1t4", ST4, PCI, 1);
    step("lmi.c2t1", ST1, PCR, 2);
    chk("lmi.c2t1.sync", sync, 1);
    step("lmi.c2t2", ST2, PCR, 2);
    step("lmi.c2t3", ST3, PCR, 2);
    chk("lmi.c2t3.irld", ir_ld, 0);
    step("lmi.c3t1", ST1, PCW, 3);
    step("lmi.c3t2", ST2, PCW, 3);
    step("lmi.c3t3", ST3, PCW, 3);
    step("lmi.c3t4", ST4, PCW, 3);
    step("lmi.c3t5", ST5, PCW, 3);
    chk("lmi.c3t5.end", instr_end, 1);
    step("lmi.next", ST1, PCI, 1);

    // JUMP with three wait states in the first PCR cycle
    clr_dec(); d_jump = 1'b1;
    step("jmp.c1t2", ST2, PCI, 1);
    step("jmp.c1t3", ST3, PCI, 1);
    step("jmp.c1t4", ST4, PCI, 1);
    step("jmp.c2t1", ST1, PCR, 2);
    step("jmp.c2t2", ST2, PCR, 2);
    ready = 1'b0;
    step("jmp.w1", SW, PCR, 2);
    step("jmp.w2", SW, PCR, 2);
    step("jmp.w3", SW, PCR, 2);
    ready = 1'b1;
    step("jmp.c2t3", ST3, PCR, 2);
    step("jmp.c3t1", ST1, PCR, 3);
    step("jmp.c3t2", ST2, PCR, 3);
    step("jmp.c3t3", ST3, PCR, 3);
    step("jmp.c3t4", ST4, PCR, 3);
    step("jmp.c3t5", ST5, PCR, 3);
    step("jmp.next", ST1, PCI, 1);

    // OUT: PCI + PCC, class priority over LOAD
    clr_dec(); d_out = 1'b1; d_load = 1'b1; d_src_m = 1'b1;
    step("out.c1t2", ST2, PCI, 1);
    step("out.c1t3", ST3, PCI, 1);
    step("out.c1t4", ST4, PCI, 1);
    step("out.c2t1", ST1, PCC, 2);
    step("out.c2t2", ST2, PCC, 2);
    step("out.c2t3", ST3, PCC, 2);
    step("out.c2t4", ST4, PCC, 2);
    step("out.c2t5", ST5, PCC, 2);
    step("out.next", ST1, PCI, 1);

    // HLT: stop, ignore READY, resume on interrupt via T1I
    clr_dec(); ir = 8'h00; d_jump = 1'b1;
    step("hlt.t2", ST2, PCI, 1);
    step("hlt.t3", ST3, PCI, 1);
    step("hlt.t4", ST4, PCI, 1);
    for (int i = 0; i < 10; i++) begin
      ready = i[0];
      step("hlt.stop", SSTP, PCI, 1);
      chk("hlt.stop.end", instr_end, 0);
    end
    ready = 1'b1; intr = 1'b1;
    step("hlt.t1i", ST1I, PCI, 1);
    chk("hlt.t1i.ack", int_ack, 1);
    chk("hlt.t1i.sync", sync, 1);
    intr = 1'b0;
    clr_dec(); d_alu = 1'b1;
    step("int.t2", ST2, PCI, 1);
    chk("int.t2.ack", int_ack, 0);
    step("int.t3", ST3, PCI, 1);
    step("int.t4", ST4, PCI, 1);
    step("int.t5", ST5, PCI, 1);
    intr = 1'b1;
    step("int.t1i", ST1I, PCI, 1);
    chk("int.t1i.ack", int_ack, 1);
    // interrupt held only during T2 is not serviced
    step("pulse.t2", ST2, PCI, 1);
    intr = 1'b0;
    step("pulse.t3", ST3, PCI, 1);
    step("pulse.t4", ST4, PCI, 1);
    step("pulse.t5", ST5, PCI, 1);
    step("pulse.next", ST1, PCI, 1);
    chk("pulse.next.ack", int_ack, 0);

    // reset during a wait state of the PCW cycle
    clr_dec(); d_load = 1'b1; d_dst_m = 1'b1;
    step("rw.c1t2", ST2, PCI, 1);
    step("rw.c1t3", ST3, PCI, 1);
    step("rw.c1t4", ST4, PCI, 1);
    step("rw.c2t1", ST1, PCW, 2);
    ready = 1'b0;
    step("rw.c2t2", ST2, PCW, 2);
    step("rw.wait", SW, PCW, 2);
    rst_n = 1'b0;
    step("rw.rst", ST1, PCI, 1);
    chk("rw.rst.strobes", {ir_ld, int_ack, instr_end}, 0);
    rst_n = 1'b1; ready = 1'b1; clr_dec(); d_load = 1'b1;
    step("rw.after", ST2, PCI, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
